// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Width defaults apply only when the shared define file has not set them.
`ifndef LSU_DATA_SIZE
`define LSU_DATA_SIZE 32
`endif
`ifndef LSU_ADDR_SIZE
`define LSU_ADDR_SIZE 10
`endif

package lsu_pkg;

    localparam int DATA_SIZE = `LSU_DATA_SIZE;
    localparam int ADDR_SIZE = `LSU_ADDR_SIZE;

    // Access size as encoded on req_size; 2'b11 is illegal.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LD_RSP,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_ERR
    } lsu_state_e;

    // Illegal size or an access that is not naturally aligned.
    function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) ||
               (size == SZ_H && off[0]) ||
               (size == SZ_W && off != 2'b00);
    endfunction

    // Byte to word, sign- or zero-extended.
    function automatic logic [31:0] lsu_ext8(input logic [7:0] b, input logic uns);
        return {{24{b[7] & ~uns}}, b};
    endfunction

    // Halfword to word, sign- or zero-extended.
    function automatic logic [31:0] lsu_ext16(input logic [15:0] h, input logic uns);
        return {{16{h[15] & ~uns}}, h};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load extract/extend and sub-word store merge.
// The memory has no byte enables, so sub-word stores rewrite the whole word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    // Pick the addressed lane and extend it to a full word.
    always_comb begin
        o_load = i_word;
        case (i_size)
            SZ_B:    o_load = lsu_ext8(w_byte, i_unsigned);
            SZ_H:    o_load = lsu_ext16(w_half, i_unsigned);
            default: o_load = i_word;
        endcase
    end

    // Per byte lane: take store data if the lane is covered, else keep memory.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       w_sel;
            logic [7:0] w_src;
            assign w_sel = (i_size == SZ_B && i_off == LANE) ||
                           (i_size == SZ_H && i_off[1] == LANE[1]);
            assign w_src = (i_size == SZ_H) ? i_wdata[8*(gi%2) +: 8] : i_wdata[7:0];
            assign o_merge[8*gi +: 8] = w_sel ? w_src : i_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit in front of a word-only data memory.
// Translates byte requests into word accesses; sub-word stores use read-modify-write.
module dm_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = DATA_SIZE,
    parameter int DM_ADDR_W = ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 DM_enable,
    output logic                 DM_write,
    output logic [DM_ADDR_W-1:0] DM_address,
    output logic [DATA_W-1:0]    DM_in,
    input  logic [DATA_W-1:0]    DM_out
);

    lsu_state_e           r_state, w_state_next;
    logic [1:0]           r_off, w_off_next;
    logic [1:0]           r_size, w_size_next;
    logic                 r_uns, w_uns_next;
    logic [15:0]          r_wdata, w_wdata_next;
    logic                 r_dm_en, w_dm_en_next;
    logic                 r_dm_we, w_dm_we_next;
    logic [DM_ADDR_W-1:0] r_dm_addr, w_dm_addr_next;
    logic [DATA_W-1:0]    r_dm_in, w_dm_in_next;
    logic [31:0]          w_load;
    logic [31:0]          w_merge;
    logic                 w_unused;

    // Address bits above the memory range wrap and are intentionally dropped.
    assign w_unused = &{1'b0, req_addr[ADDR_W-1:DM_ADDR_W+2]};

    lsu_align u_align (
        .i_word     (DM_out),
        .i_wdata    (r_wdata),
        .i_size     (r_size),
        .i_off      (r_off),
        .i_unsigned (r_uns),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    // State and registered memory controls; reset abandons any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_off     <= '0;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_wdata   <= '0;
            r_dm_en   <= 1'b0;
            r_dm_we   <= 1'b0;
            r_dm_addr <= '0;
            r_dm_in   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_off     <= w_off_next;
            r_size    <= w_size_next;
            r_uns     <= w_uns_next;
            r_wdata   <= w_wdata_next;
            r_dm_en   <= w_dm_en_next;
            r_dm_we   <= w_dm_we_next;
            r_dm_addr <= w_dm_addr_next;
            r_dm_in   <= w_dm_in_next;
        end
    end

    // Next state and the memory controls for the state being entered.
    always_comb begin
        w_state_next   = r_state;
        w_off_next     = r_off;
        w_size_next    = r_size;
        w_uns_next     = r_uns;
        w_wdata_next   = r_wdata;
        w_dm_en_next   = 1'b0;
        w_dm_we_next   = 1'b0;
        w_dm_addr_next = r_dm_addr;
        w_dm_in_next   = r_dm_in;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_off_next   = req_addr[1:0];
                    w_size_next  = req_size;
                    w_uns_next   = req_unsigned;
                    w_wdata_next = req_wdata[15:0];
                    if (lsu_bad_access(req_size, req_addr[1:0])) begin
                        w_state_next = ST_ERR;
                    end else begin
                        w_dm_en_next   = 1'b1;
                        w_dm_addr_next = req_addr[DM_ADDR_W+1:2];
                        if (!req_we) begin
                            w_state_next = ST_LOAD;
                        end else if (req_size == SZ_W) begin
                            w_state_next = ST_STORE;
                            w_dm_we_next = 1'b1;
                            w_dm_in_next = req_wdata;
                        end else begin
                            w_state_next = ST_RMW_RD;
                        end
                    end
                end
            end
            ST_LOAD:   w_state_next = ST_LD_RSP;
            ST_RMW_RD: begin
                w_state_next = ST_RMW_WR;
                w_dm_en_next = 1'b1;
                w_dm_we_next = 1'b1;
            end
            ST_RMW_WR: begin
                w_state_next = ST_IDLE;
                w_dm_in_next = w_merge;
            end
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_LD_RSP) || (r_state == ST_STORE) ||
                        (r_state == ST_RMW_WR) || (r_state == ST_ERR);
    assign resp_err   = (r_state == ST_ERR);
    assign resp_rdata = (r_state == ST_LD_RSP) ? w_load : '0;

    assign DM_enable  = r_dm_en;
    assign DM_write   = r_dm_we;
    assign DM_address = r_dm_addr;
    // Read data only exists in the write cycle of an RMW, so the merged word
    // bypasses the register there; otherwise DM_in is the registered value.
    assign DM_in      = (r_state == ST_RMW_WR) ? w_merge : r_dm_in;

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu against a byte-addressed reference memory.
module tb_dm_lsu;

    localparam int AW     = 10;
    localparam int NWORDS = 1 << AW;
    localparam int NBYTES = 4 * NWORDS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic          req_unsigned = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          req_ready, resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          DM_enable, DM_write;
    logic [AW-1:0] DM_address;
    logic [31:0]   DM_in;
    logic [31:0]   DM_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]   mem [0:NWORDS-1];
    logic [7:0]    ref_mem [0:NBYTES-1];
    int            en_cnt = 0;
    int            we_cnt = 0;
    int            we_wo_en = 0;
    logic [AW-1:0] last_addr;

    typedef struct {
        bit          to;
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          en;
        int          wr;
        logic [AW-1:0] addr;
    } obs_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } dir_t;

    dir_t dir_tab [0:17] = '{
        '{1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0},
        '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF},
        '{1'b1, 2'd2, 1'b0, 32'h10,       32'h11223344, 32'h0},
        '{1'b1, 2'd0, 1'b0, 32'h11,       32'hFFFFFFA5, 32'h0},
        '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'h1122A544},
        '{1'b0, 2'd0, 1'b0, 32'h11,       32'h0,        32'hFFFFFFA5},
        '{1'b0, 2'd0, 1'b1, 32'h11,       32'h0,        32'h000000A5},
        '{1'b1, 2'd2, 1'b0, 32'h14,       32'h0,        32'h0},
        '{1'b1, 2'd1, 1'b0, 32'h16,       32'h12348001, 32'h0},
        '{1'b0, 2'd2, 1'b0, 32'h14,       32'h0,        32'h80010000},
        '{1'b0, 2'd1, 1'b0, 32'h16,       32'h0,        32'hFFFF8001},
        '{1'b0, 2'd1, 1'b1, 32'h16,       32'h0,        32'h00008001},
        '{1'b0, 2'd2, 1'b0, 32'h13,       32'h0,        32'h0},
        '{1'b0, 2'd1, 1'b0, 32'h15,       32'h0,        32'h0},
        '{1'b0, 2'd3, 1'b0, 32'h10,       32'h0,        32'h0},
        '{1'b1, 2'd1, 1'b0, 32'h1001,     32'h5555,     32'h0},
        '{1'b1, 2'd2, 1'b0, 32'h80001018, 32'hCAFEF00D, 32'h0},
        '{1'b0, 2'd2, 1'b0, 32'h18,       32'h0,        32'hCAFEF00D}
    };

    always #5 clk = ~clk;

    dm_lsu #(.ADDR_W(32), .DATA_W(32), .DM_ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .DM_enable    (DM_enable),
        .DM_write     (DM_write),
        .DM_address   (DM_address),
        .DM_in        (DM_in),
        .DM_out       (DM_out)
    );

    // Word memory: read data valid only the cycle after a read, noise otherwise.
    always @(posedge clk) begin
        if (DM_enable && DM_write) mem[DM_address] <= DM_in;
        if (DM_enable && !DM_write) DM_out <= mem[DM_address];
        else DM_out <= $urandom;
    end

    // Count memory-port activity for per-transaction access checks.
    always @(posedge clk) begin
        if (DM_enable) begin
            en_cnt++;
            last_addr = DM_address;
        end
        if (DM_write) we_cnt++;
        if (DM_write && !DM_enable) we_wo_en++;
    end

    // Reference: byte-addressed memory, little-endian, addresses wrap at NBYTES.
    function automatic void model(input bit we, input int size, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output bit err, output logic [31:0] rdata,
                                  output int lat, output int en, output int wr);
        int base;
        int n;
        logic [63:0] v;
        base  = int'(addr % NBYTES);
        err   = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
        rdata = 32'h0;
        lat = 1; en = 0; wr = 0;
        if (err) return;
        n = 1 << size;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wdata >> (8 * i));
            lat = (n == 4) ? 1 : 2;
            en  = (n == 4) ? 1 : 2;
            wr  = 1;
        end else begin
            v = 64'h0;
            for (int i = 0; i < n; i++) v = v + (64'(ref_mem[base + i]) << (8 * i));
            if (!uns && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
            rdata = v[31:0];
            lat = 2; en = 1; wr = 0;
        end
    endfunction

    // Drive one request, wait for its response, and report what was observed.
    task automatic issue(input bit we, input int size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold, output obs_t o);
        int n;
        int e0;
        int w0;
        o.to = 0; o.err = 0; o.rdata = 32'h0; o.lat = 0; o.en = 0; o.wr = 0; o.addr = '0;
        req_we = we; req_size = 2'(size); req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            o.to = 1;
            req_valid = 1'b0;
            return;
        end
        e0 = en_cnt;
        w0 = we_cnt;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            req_addr = $urandom; req_size = 2'($urandom);
            req_we = 1'($urandom); req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        n = 1;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            o.to = 1;
            req_valid = 1'b0;
            return;
        end
        o.lat = n; o.err = resp_err; o.rdata = resp_rdata;
        @(posedge clk);
        #1;
        o.en = en_cnt - e0;
        o.wr = we_cnt - w0;
        o.addr = last_addr;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({req_ready, resp_valid, resp_err, DM_enable, DM_write} !== 5'b10000) begin
                n_bad++;
                $display("FAIL reset_ctrl[%0d]: got rdy/rv/err/en/wr=%b want 10000", k,
                         {req_ready, resp_valid, resp_err, DM_enable, DM_write});
            end
            n_cmp++;
            if (resp_rdata !== 32'h0) begin
                n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, resp_rdata);
            end
            n_cmp++;
            if (DM_address !== '0) begin
                n_bad++; $display("FAIL reset_addr[%0d]: got %h want 0", k, DM_address);
            end
            n_cmp++;
            if (DM_in !== 32'h0) begin
                n_bad++; $display("FAIL reset_din[%0d]: got %h want 0", k, DM_in);
            end
            rst = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_directed();
        obs_t o;
        bit eerr;
        logic [31:0] erd;
        int elat, een, ewr;
        logic [AW-1:0] ea;
        for (int i = 0; i < 18; i++) begin
            model(dir_tab[i].we, int'(dir_tab[i].size), dir_tab[i].uns, dir_tab[i].addr,
                  dir_tab[i].wdata, eerr, erd, elat, een, ewr);
            ea = dir_tab[i].addr[AW+1:2];
            issue(dir_tab[i].we, int'(dir_tab[i].size), dir_tab[i].uns, dir_tab[i].addr,
                  dir_tab[i].wdata, 1'b0, o);
            $display("dir %0d: we=%0d sz=%0d uns=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d en=%0d wr=%0d",
                     i, dir_tab[i].we, dir_tab[i].size, dir_tab[i].uns, dir_tab[i].addr,
                     dir_tab[i].wdata, o.err, o.rdata, o.lat, o.en, o.wr);
            n_cmp++;
            if (o.to !== 1'b0) begin
                n_bad++; $display("FAIL dir%0d_timeout: got timeout want response", i);
            end else begin
                n_cmp++;
                if (o.err !== eerr) begin n_bad++; $display("FAIL dir%0d_err: got %0d want %0d", i, o.err, eerr); end
                n_cmp++;
                if (o.rdata !== dir_tab[i].exp) begin n_bad++; $display("FAIL dir%0d_rdata: got %h want %h", i, o.rdata, dir_tab[i].exp); end
                n_cmp++;
                if (o.lat != elat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, o.lat, elat); end
                n_cmp++;
                if (o.en != een) begin n_bad++; $display("FAIL dir%0d_enable_cycles: got %0d want %0d", i, o.en, een); end
                n_cmp++;
                if (o.wr != ewr) begin n_bad++; $display("FAIL dir%0d_write_cycles: got %0d want %0d", i, o.wr, ewr); end
                if (een > 0) begin
                    n_cmp++;
                    if (o.addr !== ea) begin n_bad++; $display("FAIL dir%0d_dm_address: got %h want %h", i, o.addr, ea); end
                end
            end
        end
    endtask

    task automatic test_random(input bit hold, input int count);
        obs_t o;
        bit eerr, we, uns;
        logic [31:0] erd, addr, wdata;
        int elat, een, ewr, r, size;
        logic [AW-1:0] ea;
        for (int i = 0; i < count; i++) begin
            we    = 1'($urandom);
            uns   = 1'($urandom);
            r     = $urandom_range(0, 9);
            size  = (r == 9) ? 3 : r / 3;
            addr  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom << 12);
            if (size < 3 && $urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            wdata = $urandom;
            model(we, size, uns, addr, wdata, eerr, erd, elat, een, ewr);
            ea = addr[AW+1:2];
            issue(we, size, uns, addr, wdata, hold, o);
            $display("%s %0d: we=%0d sz=%0d uns=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d en=%0d wr=%0d",
                     hold ? "b2b" : "rnd", i, we, size, uns, addr, wdata,
                     o.err, o.rdata, o.lat, o.en, o.wr);
            n_cmp++;
            if (o.to !== 1'b0) begin
                n_bad++; $display("FAIL rnd%0d_timeout: got timeout want response", i);
            end else begin
                n_cmp++;
                if (o.err !== eerr) begin n_bad++; $display("FAIL rnd%0d_err: got %0d want %0d", i, o.err, eerr); end
                n_cmp++;
                if (o.rdata !== erd) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, o.rdata, erd); end
                n_cmp++;
                if (o.lat != elat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, o.lat, elat); end
                n_cmp++;
                if (o.en != een) begin n_bad++; $display("FAIL rnd%0d_enable_cycles: got %0d want %0d", i, o.en, een); end
                n_cmp++;
                if (o.wr != ewr) begin n_bad++; $display("FAIL rnd%0d_write_cycles: got %0d want %0d", i, o.wr, ewr); end
                if (een > 0) begin
                    n_cmp++;
                    if (o.addr !== ea) begin n_bad++; $display("FAIL rnd%0d_dm_address: got %h want %h", i, o.addr, ea); end
                end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_random(1'b1, 40);
    endtask

    task automatic test_reset_mid_rmw();
        int w0;
        int rv_seen;
        @(negedge clk);
        w0 = we_cnt;
        rv_seen = 0;
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h0000005A; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if ({DM_enable, DM_write} !== 2'b10) begin
            n_bad++; $display("FAIL rstmid_read_phase: got en/wr=%b want 10", {DM_enable, DM_write});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, DM_enable, DM_write} !== 5'b10000 ||
            resp_rdata !== 32'h0 || DM_address !== '0 || DM_in !== 32'h0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got rdy/rv/err/en/wr=%b rdata=%h addr=%h din=%h want 10000/0/0/0",
                     {req_ready, resp_valid, resp_err, DM_enable, DM_write}, resp_rdata, DM_address, DM_in);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) rv_seen++;
        end
        n_cmp++;
        if (rv_seen != 0) begin n_bad++; $display("FAIL rstmid_resp_valid: got %0d pulses want 0", rv_seen); end
        n_cmp++;
        if (we_cnt != w0) begin n_bad++; $display("FAIL rstmid_write_pulses: got %0d want 0", we_cnt - w0); end
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_memory_image();
        int diffs;
        logic [31:0] want;
        diffs = 0;
        for (int w = 0; w < NWORDS; w++) begin
            want = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
            if (mem[w] !== want) begin
                if (diffs < 4) $display("memory word %0d: got %h want %h", w, mem[w], want);
                diffs++;
            end
        end
        n_cmp++;
        if (diffs != 0) begin n_bad++; $display("FAIL memory_image: got %0d differing words want 0", diffs); end
        n_cmp++;
        if (we_wo_en != 0) begin n_bad++; $display("FAIL write_without_enable: got %0d cycles want 0", we_wo_en); end
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < NWORDS; i++) begin
            w = $urandom;
            mem[i] <= w;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
        end
        test_reset();
        test_directed();
        test_random(1'b0, 60);
        test_back_to_back();
        test_reset_mid_rmw();
        test_random(1'b0, 10);
        test_memory_image();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
